// File: rtl/sll_iter_pkg.sv
// Shared constants and state encoding for the iterative 32-bit left shifter.
package sll_iter_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned STEP_W  = 3;

  localparam logic [STEP_W-1:0] LAST_STEP = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sll_step_32.sv
// One stage of the iterative shifter: optionally shift left by 2**step, zero-filled.
module sll_step_32
  import sll_iter_pkg::*;
(
  input  logic [WIDTH-1:0]  in,
  input  logic [STEP_W-1:0] step,
  input  logic              en,
  output logic [WIDTH-1:0]  out
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = in;
    unique case (step)
      3'd0:    shifted = in << 1;
      3'd1:    shifted = in << 2;
      3'd2:    shifted = in << 4;
      3'd3:    shifted = in << 8;
      3'd4:    shifted = in << 16;
      default: shifted = in;
    endcase
  end

  assign out = en ? shifted : in;

endmodule

// File: rtl/sll_iter_32.sv
// Multi-cycle logical left shifter, one shamt bit per cycle LSB first, valid/ready on both sides.
module sll_iter_32
  import sll_iter_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  state_t              state, state_d;
  logic [WIDTH-1:0]    acc, acc_d;
  logic [WIDTH-1:0]    res, res_d;
  logic [WIDTH-1:0]    stage_out;
  logic [SHAMT_W-1:0]  amt, amt_d;
  logic [STEP_W-1:0]   step, step_d;

  sll_step_32 u_step (
    .in   (acc),
    .step (step),
    .en   (amt[step]),
    .out  (stage_out)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      res   <= '0;
      amt   <= '0;
      step  <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      res   <= res_d;
      amt   <= amt_d;
      step  <= step_d;
    end
  end

  // The visible result is a separate register so it stays put in IDLE and SHIFT.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    res_d   = res;
    amt_d   = amt;
    step_d  = step;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = data_a;
          amt_d   = shamt;
          step_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = stage_out;
        if (step == LAST_STEP) begin
          res_d   = stage_out;
          state_d = ST_DONE;
        end else begin
          step_d = step + 3'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_SHIFT);
  assign out_valid = (state == ST_DONE);
  assign result    = res;

endmodule
